// File: rtl/rand_share_arbiter.sv
// rand_share_arbiter: one 8-bit XNOR LFSR shared round-robin among NREQ
// requesters, stirred STEPS cycles before each grant.
// Ports: clk, reset (sync, active-high), seed_load/seed_val (reseed),
//   req (level requests), ack (one-hot grant pulse), rdata (granted value),
//   gnt_id (last grant index), busy (not idle).
// Optional `RAND_RANGE_EN: adds rlimit; grant waits until lfsr <= rlimit.
module rand_share_arbiter #(
  parameter int              NREQ  = 4,
  parameter int              IDW   = 2,
  parameter int              WIDTH = 8,
  parameter int              STEPS = 3,
  parameter logic [WIDTH-1:0] SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
`ifdef RAND_RANGE_EN
  input  logic [WIDTH-1:0] rlimit,
`endif
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic [WIDTH-1:0] rdata,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STIR  = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(STEPS - 1);
  localparam logic [WIDTH-1:0] ALL1 = '1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_lfsr;
  logic [IDW-1:0]   r_rr;
  logic [IDW-1:0]   r_cand;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_rdata;
  logic [IDW-1:0]   r_gnt_id;

  logic             w_fb;
  logic             w_found;
  logic [IDW-1:0]   w_pick;
  logic             w_in_range;
  logic             w_capture;
  logic [NREQ-1:0]  w_ack;

  assign w_fb = ~(r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]);

`ifdef RAND_RANGE_EN
  assign w_in_range = (r_lfsr <= rlimit);
`else
  assign w_in_range = 1'b1;
`endif

  // First set request at or above the rr pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr;
    for (int k = 0; k < NREQ; k++) begin
      automatic int j = int'(r_rr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_pick  = IDW'(j);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) w_next = STIR;
      end
      STIR: begin
        if (!req[r_cand]) begin
          w_next = IDLE;
        end else if (!seed_load && r_cnt == LAST
                     && w_in_range) begin
          w_next    = GRANT;
          w_capture = 1'b1;
        end
      end
      GRANT: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_ack = '0;
    if (r_state == GRANT) w_ack[r_cand] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (seed_load) begin
      r_lfsr <= (seed_val == ALL1) ? SEED : seed_val;
    end else begin
      r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr     <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_gnt_id <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_cand <= w_pick;
            r_cnt  <= '0;
          end
        end
        STIR: begin
          // Reseeding restarts the stir so the grant
          // never sees a freshly loaded seed.
          if (seed_load) begin
            r_cnt <= '0;
          end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 4'd1;
          end
          if (w_capture) begin
            r_rdata  <= r_lfsr;
            r_gnt_id <= r_cand;
          end
        end
        GRANT: begin
          r_rr <= (r_cand == IDW'(NREQ - 1)) ?
                  '0 : r_cand + IDW'(1);
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign ack    = w_ack;
  assign rdata  = r_rdata;
  assign gnt_id = r_gnt_id;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_rand_share_arbiter.sv
// tb_rand_share_arbiter: directed self-checking bench for
// rand_share_arbiter (default build, optional range case under macro).
module tb_rand_share_arbiter;

  logic       clk;
  logic       reset;
  logic       seed_load;
  logic [7:0] seed_val;
  logic [3:0] req;
  logic [3:0] ack;
  logic [7:0] rdata;
  logic [1:0] gnt_id;
  logic       busy;
`ifdef RAND_RANGE_EN
  logic [7:0] rlimit;
`endif

  int checks   = 0;
  int failures = 0;

  rand_share_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed_val  (seed_val),
`ifdef RAND_RANGE_EN
    .rlimit    (rlimit),
`endif
    .req       (req),
    .ack       (ack),
    .rdata     (rdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset asserted-and-sampled; caller releases it.
  task automatic do_reset();
    reset     = 1'b1;
    seed_load = 1'b0;
    seed_val  = 8'h00;
    req       = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut.r_lfsr !== 8'hA5) begin
      failures++;
      $display("FAIL reset_lfsr got=%h exp=a5", dut.r_lfsr);
    end
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack_busy got=%b/%b exp=0000/0", ack, busy);
    end
    checks++;
    if (rdata !== 8'h00 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d exp=00/0", rdata, gnt_id);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_l [4] = '{8'h4B, 8'h96, 8'h2D, 8'h5B};
    do_reset();
    reset = 1'b0;
    req   = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut.r_lfsr !== exp_l[i]) begin
        failures++;
        $display("FAIL single_lfsr[%0d] got=%h exp=%h",
                 i, dut.r_lfsr, exp_l[i]);
      end
      checks++;
      if (ack !== ((i == 3) ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL single_ack[%0d] got=%b", i, ack);
      end
    end
    checks++;
    if (rdata !== 8'h2D || gnt_id !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got=%h/%0d/%b exp=2d/2/1",
               rdata, gnt_id, busy);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || rdata !== 8'h2D) begin
      failures++;
      $display("FAIL single_after got=%b/%b/%h exp=0000/0/2d",
               ack, busy, rdata);
    end
  endtask

  task automatic test_round_robin();
    int exp_t  [5] = '{4, 9, 14, 19, 24};
    int exp_id [5] = '{0, 1, 2, 3, 0};
    int n = 0;
    do_reset();
    reset = 1'b0;
    req   = 4'b1111;
    for (int t = 1; t <= 26; t++) begin
      tick();
      if (ack !== 4'b0000) begin
        checks++;
        if (!$onehot(ack) || n >= 5) begin
          failures++;
          $display("FAIL rr_onehot t=%0d got=%b", t, ack);
        end else begin
          checks++;
          if (ack !== (4'b0001 << exp_id[n]) || t != exp_t[n]
              || gnt_id !== 2'(exp_id[n])) begin
            failures++;
            $display("FAIL rr_grant%0d got=%b@%0d id=%0d exp=%0d@%0d",
                     n, ack, t, gnt_id, exp_id[n], exp_t[n]);
          end
          if (n < 2) begin
            checks++;
            if (rdata !== ((n == 0) ? 8'h2D : 8'hBA)) begin
              failures++;
              $display("FAIL rr_rdata%0d got=%h", n, rdata);
            end
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=5", n);
    end
    req = 4'b0000;
  endtask

  task automatic test_seed();
    logic [7:0] sv [5] = '{8'h01, 8'h00, 8'hFF, 8'h00, 8'h3C};
    logic       sl [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ex [5] = '{8'h01, 8'h03, 8'hA5, 8'h4B, 8'h3C};
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seed_load = sl[i];
      seed_val  = sv[i];
      tick();
      checks++;
      if (dut.r_lfsr !== ex[i]) begin
        failures++;
        $display("FAIL seed[%0d] got=%h exp=%h", i, dut.r_lfsr, ex[i]);
      end
    end
    seed_load = 1'b0;
  endtask

  task automatic test_drop();
    int waited = 0;
    do_reset();
    reset = 1'b0;
    req   = 4'b0010;
    tick();
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || 2'(dut.r_state) !== 2'd0) begin
      failures++;
      $display("FAIL drop_idle got=%b/%b/%0d exp=0000/0/0",
               ack, busy, dut.r_state);
    end
    req = 4'b1010;
    while (ack === 4'b0000 && waited < 10) begin
      tick();
      waited++;
    end
    checks++;
    if (ack !== 4'b0010 || waited != 4) begin
      failures++;
      $display("FAIL drop_regrant got=%b after=%0d exp=0010 after=4",
               ack, waited);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0001;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || dut.r_lfsr !== 8'hA5
        || rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid got=%b/%b/%h/%h exp=0000/0/a5/00",
               ack, busy, dut.r_lfsr, rdata);
    end
    tick();
    checks++;
    if (ack !== 4'b0000 || 2'(dut.r_state) !== 2'd0) begin
      failures++;
      $display("FAIL reset_hold got=%b/%0d", ack, dut.r_state);
    end
    reset = 1'b0;
    req   = 4'b0000;
    tick();
  endtask

`ifdef RAND_RANGE_EN
  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], ~(v[7] ^ v[5] ^ v[4] ^ v[3])};
  endfunction

  task automatic test_range();
    logic [7:0] m = 8'hA5;
    int exp_t = 0;
    int waited = 0;
    // Stir 3 cycles, then keep stepping until within the limit.
    for (int k = 0; k < 3; k++) m = step(m);
    exp_t = 4;
    while (m > 8'h0F) begin
      m = step(m);
      exp_t++;
    end
    rlimit = 8'h0F;
    do_reset();
    reset = 1'b0;
    req   = 4'b0001;
    while (ack === 4'b0000 && waited < 300) begin
      tick();
      waited++;
    end
    checks++;
    if (ack !== 4'b0001 || waited != exp_t || rdata !== m) begin
      failures++;
      $display("FAIL range got=%b@%0d rdata=%h exp=0001@%0d rdata=%h",
               ack, waited, rdata, exp_t, m);
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    seed_load = 1'b0;
    seed_val  = 8'h00;
    req       = 4'b0000;
`ifdef RAND_RANGE_EN
    rlimit    = 8'hFF;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_seed();
    test_drop();
    test_reset_mid();
`ifdef RAND_RANGE_EN
    test_range();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_share_arbiter.md
Name: rand_share_arbiter

Overview:
- Owns one maximal-length 8-bit XNOR LFSR and shares it among NREQ game requesters (duck spawn X, flight direction, spawn delay, colour).
- Uses round-robin arbitration.
- Before each grant, the LFSR is stirred for STEPS cycles so consecutive consumers never get adjacent sequence values.
- Sits between the game-control FSM and the object-spawn logic.

Parameters:
- NREQ, 4: number of requesters.
- IDW, 2: width of grant index; must equal clog2(NREQ).
- WIDTH, 8: LFSR/data width. The tap set below is defined for 8 only.
- STEPS, 3: stir cycles before each grant; legal range 1..15.
- SEED, 8'hA5: reset and fallback seed; must not be 8'hFF.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- seed_load  in  1  load seed_val into LFSR this cycle.
- seed_val  in  WIDTH  new seed.
- req  in  NREQ  level requests; each held until its ack.
- ack  out  NREQ  one-hot, one-cycle grant pulse.
- rdata  out  WIDTH  random value for the granted requester; valid during ack, held until the next grant.
- gnt_id  out  IDW  index of the last grant.
- busy  out  1  high in STIR or GRANT.

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is clk.
  - Reset values: lfsr=SEED, state=IDLE, rr pointer=0, stir count=0, ack=0, rdata=0, gnt_id=0, busy=0.
  - Reset mid-operation aborts any grant; no ack is issued.
- LFSR:
  - Advances every clock when not in reset and not loading: lfsr <= {lfsr[6:0], ~(lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3])}.
  - Period is 255; 8'hFF is the lockup state and never occurs.
- seed_load:
  - lfsr <= seed_val, except seed_val==8'hFF loads SEED instead.
  - Takes priority over stepping.
  - If asserted in STIR, the stir count restarts at 0.
- FSM, 3 states:
  - IDLE: if any req bit is set, choose the first set bit searching upward from the rr pointer, wrapping. Latch it as the candidate, go to STIR, count=0.
  - STIR:
    - count increments each cycle.
    - If the candidate's req drops, return to IDLE with no ack; rr pointer unchanged.
    - When count==STEPS-1 and req is still high, capture rdata <= current lfsr, gnt_id <= candidate, go to GRANT.
  - GRANT:
    - ack[candidate]=1 for exactly this cycle.
    - rr pointer <= candidate+1, wrapping at NREQ.
    - Next state is IDLE.
- Latency: req sampled in IDLE → ack asserted STEPS+1 cycles later. The minimum spacing between two grants is STEPS+2 cycles.
- Requests arriving during STIR or GRANT wait; no queue beyond the req levels.
- The requester must drop req on the cycle after ack. A req still high in IDLE is treated as a new request.
- busy = (state != IDLE).

Optional Feature:
- Macro: RAND_RANGE_EN.
- When defined:
  - Adds input rlimit[WIDTH].
  - When count reaches STEPS-1 with lfsr > rlimit, stay in STIR, stepping one cycle at a time, until lfsr <= rlimit; then capture and go to GRANT.
  - Value 0 is always reachable, so the wait is bounded at 254 extra cycles.
  - rlimit is sampled every STIR cycle.
- When undefined: no rlimit port; rdata is the raw LFSR value after exactly STEPS stir cycles.

Test Plan:
- Reset, then req=4'b0100 held from the first post-reset cycle → IDLE sees the request while lfsr=A5, stirs through 4B, 96, 2D. ack=4'b0100 for 1 cycle, 4 cycles after the request is sampled; rdata=8'h2D, gnt_id=2; lfsr=8'h5B in the GRANT cycle.
- req=4'b1111 held continuously from reset → grants in order 0,1,2,3,0, spaced 5 cycles apart; ack always one-hot.
- seed_load=1 with seed_val=8'hFF → lfsr=8'hA5 next cycle. seed_val=8'h01 → lfsr=8'h01, and after one step 8'h03.
- req[1] high, dropped on the 2nd STIR cycle → no ack, back to IDLE, busy=0; next request from req[1] is still granted first.
- Assert reset during STIR → no ack, state IDLE, lfsr=8'hA5, rdata=0.
- RAND_RANGE_EN, rlimit=8'h0F, seed 8'hA5, req[0] → rdata <= 8'h0F; ack is delayed until the first lfsr value <= 8'h0F after the 3 stir cycles.
